// File: rtl/multicycle_control_unit.sv
// Multi-cycle CPU controller: sequences IF/ID/EXE/MEM/WB and drives
// every datapath write enable and mux select from state + opcode.
module multicycle_control_unit (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       sign,
   output logic [2:0] state,
   output logic       PCWre,
   output logic       IRWre,
   output logic       RegWre,
   output logic       mRD,
   output logic       mWR,
   output logic       ALUSrcA,
   output logic       ALUSrcB,
   output logic       ExtSel,
   output logic       DBDataSrc,
   output logic       WrRegDSrc,
   output logic [1:0] RegDst,
   output logic [1:0] PCSrc,
   output logic [2:0] ALUOp
);

   typedef enum logic [2:0] {
      S_IF     = 3'b000,
      S_ID     = 3'b001,
      S_EXE_LS = 3'b010,
      S_MEM    = 3'b011,
      S_WB_LD  = 3'b100,
      S_EXE_BR = 3'b101,
      S_EXE_AL = 3'b110,
      S_WB_AL  = 3'b111
   } state_t;

   typedef enum logic [2:0] {
      C_NOP,
      C_RTYPE,
      C_IMM,
      C_BR,
      C_LS,
      C_JUMP,
      C_HALT
   } cls_t;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_ADDIU = 6'b000010;
   localparam logic [5:0] OP_AND   = 6'b010000;
   localparam logic [5:0] OP_ANDI  = 6'b010001;
   localparam logic [5:0] OP_ORI   = 6'b010010;
   localparam logic [5:0] OP_SLL   = 6'b011000;
   localparam logic [5:0] OP_SLTI  = 6'b100111;
   localparam logic [5:0] OP_SW    = 6'b110000;
   localparam logic [5:0] OP_LW    = 6'b110001;
   localparam logic [5:0] OP_BEQ   = 6'b110100;
   localparam logic [5:0] OP_BNE   = 6'b110101;
   localparam logic [5:0] OP_BLTZ  = 6'b110110;
   localparam logic [5:0] OP_J     = 6'b111000;
   localparam logic [5:0] OP_JR    = 6'b111001;
   localparam logic [5:0] OP_JAL   = 6'b111010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   state_t     r_state;
   state_t     w_next;
   cls_t       w_cls;
   logic [2:0] w_aop;
   logic       w_sa;
   logic       w_sb;
   logic       w_ext;
   logic       w_take;
   logic       w_is_lw;

   // Per-opcode class and the ALU settings used from EXE until retire
   always_comb begin
      w_cls = C_NOP;
      w_aop = 3'b000;
      w_sa  = 1'b0;
      w_sb  = 1'b0;
      w_ext = 1'b0;
      case (opcode)
         OP_ADD: w_cls = C_RTYPE;
         OP_SUB: begin
            w_cls = C_RTYPE;
            w_aop = 3'b001;
         end
         OP_ADDIU: begin
            w_cls = C_IMM;
            w_sb  = 1'b1;
            w_ext = 1'b1;
         end
         OP_AND: begin
            w_cls = C_RTYPE;
            w_aop = 3'b100;
         end
         OP_ANDI: begin
            w_cls = C_IMM;
            w_aop = 3'b100;
            w_sb  = 1'b1;
         end
         OP_ORI: begin
            w_cls = C_IMM;
            w_aop = 3'b011;
            w_sb  = 1'b1;
         end
         OP_SLL: begin
            w_cls = C_RTYPE;
            w_aop = 3'b010;
            w_sa  = 1'b1;
         end
         OP_SLTI: begin
            w_cls = C_IMM;
            w_aop = 3'b101;
            w_sb  = 1'b1;
            w_ext = 1'b1;
         end
         OP_SW, OP_LW: begin
            w_cls = C_LS;
            w_sb  = 1'b1;
            w_ext = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            w_cls = C_BR;
            w_aop = 3'b001;
            w_ext = 1'b1;
         end
         OP_BLTZ: begin
            w_cls = C_BR;
            w_ext = 1'b1;
         end
         OP_J, OP_JR, OP_JAL: w_cls = C_JUMP;
         OP_HALT: w_cls = C_HALT;
         default: w_cls = C_NOP;
      endcase
   end

   assign w_is_lw = (opcode == OP_LW);
   assign w_take  = ((opcode == OP_BEQ) & zero)
                  | ((opcode == OP_BNE) & ~zero)
                  | ((opcode == OP_BLTZ) & sign);

   always_comb begin
      w_next = S_IF;
      unique case (r_state)
         S_IF: w_next = S_ID;
         S_ID: begin
            case (w_cls)
               C_RTYPE, C_IMM: w_next = S_EXE_AL;
               C_BR:           w_next = S_EXE_BR;
               C_LS:           w_next = S_EXE_LS;
               C_HALT:         w_next = S_ID;
               default:        w_next = S_IF;
            endcase
         end
         S_EXE_AL: w_next = S_WB_AL;
         S_WB_AL:  w_next = S_IF;
         S_EXE_BR: w_next = S_IF;
         S_EXE_LS: w_next = S_MEM;
         S_MEM:    w_next = w_is_lw ? S_WB_LD : S_IF;
         S_WB_LD:  w_next = S_IF;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) r_state <= S_IF;
      else       r_state <= w_next;
   end

   assign state = r_state;

   always_comb begin
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      RegWre    = 1'b0;
      mRD       = 1'b0;
      mWR       = 1'b0;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      ExtSel    = 1'b0;
      DBDataSrc = 1'b0;
      WrRegDSrc = 1'b0;
      RegDst    = 2'b00;
      PCSrc     = 2'b00;
      ALUOp     = 3'b000;
      unique case (r_state)
         S_IF: IRWre = 1'b1;
         S_ID: begin
            if (w_cls == C_JUMP) begin
               PCWre  = 1'b1;
               PCSrc  = (opcode == OP_JR) ? 2'b10 : 2'b11;
               RegWre = (opcode == OP_JAL);
            end else if (w_cls == C_NOP) begin
               PCWre = 1'b1;
            end
         end
         S_EXE_AL, S_EXE_LS: begin
            ALUOp   = w_aop;
            ALUSrcA = w_sa;
            ALUSrcB = w_sb;
            ExtSel  = w_ext;
         end
         S_WB_AL: begin
            ALUOp     = w_aop;
            ALUSrcA   = w_sa;
            ALUSrcB   = w_sb;
            ExtSel    = w_ext;
            RegWre    = 1'b1;
            WrRegDSrc = 1'b1;
            RegDst    = (w_cls == C_RTYPE) ? 2'b10 : 2'b01;
            PCWre     = 1'b1;
         end
         S_EXE_BR: begin
            ALUOp  = w_aop;
            ExtSel = w_ext;
            PCWre  = 1'b1;
            PCSrc  = w_take ? 2'b01 : 2'b00;
         end
         S_MEM: begin
            ALUOp   = w_aop;
            ALUSrcB = w_sb;
            ExtSel  = w_ext;
            mRD     = w_is_lw;
            mWR     = ~w_is_lw;
            PCWre   = ~w_is_lw;
         end
         S_WB_LD: begin
            ALUOp     = w_aop;
            ALUSrcB   = w_sb;
            ExtSel    = w_ext;
            RegWre    = 1'b1;
            DBDataSrc = 1'b1;
            WrRegDSrc = 1'b1;
            RegDst    = 2'b01;
            PCWre     = 1'b1;
         end
      endcase
      // Reset kills every write strobe immediately, even mid-cycle
      if (Reset) begin
         PCWre  = 1'b0;
         IRWre  = 1'b0;
         RegWre = 1'b0;
         mRD    = 1'b0;
         mWR    = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-cycle expected control words
// are queued with their stimulus and compared at each negedge.
module tb_multicycle_control_unit;

   typedef struct packed {
      logic [2:0] st;
      logic [4:0] en;
      logic [1:0] pcs;
      logic [1:0] rd;
      logic       dbs;
      logic       wrs;
      logic [2:0] op;
      logic       sa;
      logic       sb;
      logic       ext;
   } ctl_t;

   typedef struct {
      logic [5:0] op;
      logic       z;
      logic       s;
      ctl_t       e;
   } ent_t;

   logic       CLK = 1'b0;
   logic       Reset = 1'b1;
   logic [5:0] opcode = 6'b0;
   logic       zero = 1'b0;
   logic       sign = 1'b0;
   logic [2:0] state;
   logic       PCWre, IRWre, RegWre, mRD, mWR;
   logic       ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc;
   logic [1:0] RegDst, PCSrc;
   logic [2:0] ALUOp;
   ctl_t       w_act;
   ent_t       sb_q[$];
   ent_t       ent;
   int         total = 0;
   int         bad = 0;

   multicycle_control_unit dut (
      .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
      .sign(sign), .state(state), .PCWre(PCWre), .IRWre(IRWre),
      .RegWre(RegWre), .mRD(mRD), .mWR(mWR), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .DBDataSrc(DBDataSrc),
      .WrRegDSrc(WrRegDSrc), .RegDst(RegDst), .PCSrc(PCSrc),
      .ALUOp(ALUOp)
   );

   always #5 CLK = ~CLK;

   assign w_act = {state, PCWre, IRWre, RegWre, mRD, mWR, PCSrc,
                   RegDst, DBDataSrc, WrRegDSrc, ALUOp, ALUSrcA,
                   ALUSrcB, ExtSel};

   // en = {PCWre, IRWre, RegWre, mRD, mWR}
   function automatic ctl_t c(input logic [2:0] st, input logic [4:0] en,
                              input logic [1:0] pcs, input logic [1:0] rd,
                              input logic dbs, input logic wrs,
                              input logic [2:0] op, input logic sa,
                              input logic sb, input logic ext);
      c = {st, en, pcs, rd, dbs, wrs, op, sa, sb, ext};
   endfunction

   task automatic push(input logic [5:0] op, input logic z,
                       input logic s, input ctl_t e);
      ent_t n;
      n.op = op;
      n.z  = z;
      n.s  = s;
      n.e  = e;
      sb_q.push_back(n);
   endtask

   localparam ctl_t R0   = 20'h0;
   localparam ctl_t E_IF = {3'b000, 5'b01000, 12'h0};
   localparam ctl_t E_ID = {3'b001, 17'h0};

   task automatic test_reset;
      opcode = 6'b110000;
      #3;
      total++;
      if (w_act !== R0) begin
         bad++;
         $display("FAIL reset_async got=%h want=%h", w_act, R0);
      end
      @(negedge CLK);
      opcode = 6'b111010;
      #1;
      total++;
      if (w_act !== R0) begin
         bad++;
         $display("FAIL reset_held got=%h want=%h", w_act, R0);
      end
      @(posedge CLK);
      #1 Reset = 1'b0;
   endtask

   task automatic test_alu;
      // add with zero/sign high: they must not matter outside EXE_BR
      push(6'b000000, 1, 1, E_IF);
      push(6'b000000, 1, 1, E_ID);
      push(6'b000000, 1, 1, c(3'b110, 5'b00000, 2'b00, 2'b00, 0, 0, 3'b000, 0, 0, 0));
      push(6'b000000, 1, 1, c(3'b111, 5'b10100, 2'b00, 2'b10, 0, 1, 3'b000, 0, 0, 0));
      push(6'b011000, 0, 0, E_IF);
      push(6'b011000, 0, 0, E_ID);
      push(6'b011000, 0, 0, c(3'b110, 5'b00000, 2'b00, 2'b00, 0, 0, 3'b010, 1, 0, 0));
      push(6'b011000, 0, 0, c(3'b111, 5'b10100, 2'b00, 2'b10, 0, 1, 3'b010, 1, 0, 0));
      push(6'b100111, 0, 0, E_IF);
      push(6'b100111, 0, 0, E_ID);
      push(6'b100111, 0, 0, c(3'b110, 5'b00000, 2'b00, 2'b00, 0, 0, 3'b101, 0, 1, 1));
      push(6'b100111, 0, 0, c(3'b111, 5'b10100, 2'b00, 2'b01, 0, 1, 3'b101, 0, 1, 1));
      push(6'b010010, 0, 0, E_IF);
      push(6'b010010, 0, 0, E_ID);
      push(6'b010010, 0, 0, c(3'b110, 5'b00000, 2'b00, 2'b00, 0, 0, 3'b011, 0, 1, 0));
      push(6'b010010, 0, 0, c(3'b111, 5'b10100, 2'b00, 2'b01, 0, 1, 3'b011, 0, 1, 0));
      while (sb_q.size() > 0) begin
         ent = sb_q.pop_front();
         @(negedge CLK);
         opcode = ent.op; zero = ent.z; sign = ent.s;
         #1;
         total++;
         if (w_act !== ent.e) begin
            bad++;
            $display("FAIL alu op=%b got=%h want=%h", ent.op, w_act, ent.e);
         end
      end
   endtask

   task automatic test_mem;
      push(6'b110001, 0, 0, E_IF);
      push(6'b110001, 0, 0, E_ID);
      push(6'b110001, 0, 0, c(3'b010, 5'b00000, 2'b00, 2'b00, 0, 0, 3'b000, 0, 1, 1));
      push(6'b110001, 0, 0, c(3'b011, 5'b00010, 2'b00, 2'b00, 0, 0, 3'b000, 0, 1, 1));
      push(6'b110001, 0, 0, c(3'b100, 5'b10100, 2'b00, 2'b01, 1, 1, 3'b000, 0, 1, 1));
      push(6'b110000, 0, 0, E_IF);
      push(6'b110000, 0, 0, E_ID);
      push(6'b110000, 0, 0, c(3'b010, 5'b00000, 2'b00, 2'b00, 0, 0, 3'b000, 0, 1, 1));
      push(6'b110000, 0, 0, c(3'b011, 5'b10001, 2'b00, 2'b00, 0, 0, 3'b000, 0, 1, 1));
      while (sb_q.size() > 0) begin
         ent = sb_q.pop_front();
         @(negedge CLK);
         opcode = ent.op; zero = ent.z; sign = ent.s;
         #1;
         total++;
         if (w_act !== ent.e) begin
            bad++;
            $display("FAIL mem op=%b got=%h want=%h", ent.op, w_act, ent.e);
         end
      end
   endtask

   task automatic test_branch;
      logic [5:0] ops [6];
      logic       zs  [6];
      logic       ss  [6];
      logic [1:0] pcs [6];
      logic [2:0] aop [6];
      ops = '{6'b110100, 6'b110100, 6'b110101, 6'b110101, 6'b110110, 6'b110110};
      zs  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      ss  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      pcs = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
      aop = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
      for (int i = 0; i < 6; i++) begin
         push(ops[i], zs[i], ss[i], E_IF);
         push(ops[i], zs[i], ss[i], E_ID);
         push(ops[i], zs[i], ss[i],
              c(3'b101, 5'b10000, pcs[i], 2'b00, 0, 0, aop[i], 0, 0, 1));
      end
      while (sb_q.size() > 0) begin
         ent = sb_q.pop_front();
         @(negedge CLK);
         opcode = ent.op; zero = ent.z; sign = ent.s;
         #1;
         total++;
         if (w_act !== ent.e) begin
            bad++;
            $display("FAIL branch op=%b z=%b s=%b got=%h want=%h",
                     ent.op, ent.z, ent.s, w_act, ent.e);
         end
      end
   endtask

   task automatic test_jump_nop;
      push(6'b111010, 0, 0, E_IF);
      push(6'b111010, 0, 0, c(3'b001, 5'b10100, 2'b11, 2'b00, 0, 0, 3'b000, 0, 0, 0));
      push(6'b111000, 0, 0, E_IF);
      push(6'b111000, 0, 0, c(3'b001, 5'b10000, 2'b11, 2'b00, 0, 0, 3'b000, 0, 0, 0));
      push(6'b111001, 0, 0, E_IF);
      push(6'b111001, 0, 0, c(3'b001, 5'b10000, 2'b10, 2'b00, 0, 0, 3'b000, 0, 0, 0));
      push(6'b101010, 0, 0, E_IF);
      push(6'b101010, 0, 0, c(3'b001, 5'b10000, 2'b00, 2'b00, 0, 0, 3'b000, 0, 0, 0));
      while (sb_q.size() > 0) begin
         ent = sb_q.pop_front();
         @(negedge CLK);
         opcode = ent.op; zero = ent.z; sign = ent.s;
         #1;
         total++;
         if (w_act !== ent.e) begin
            bad++;
            $display("FAIL jump op=%b got=%h want=%h", ent.op, w_act, ent.e);
         end
      end
   endtask

   task automatic test_back_to_back;
      push(6'b000001, 0, 0, E_IF);
      push(6'b000001, 0, 0, E_ID);
      push(6'b000001, 0, 0, c(3'b110, 5'b00000, 2'b00, 2'b00, 0, 0, 3'b001, 0, 0, 0));
      push(6'b000001, 0, 0, c(3'b111, 5'b10100, 2'b00, 2'b10, 0, 1, 3'b001, 0, 0, 0));
      push(6'b000010, 0, 0, E_IF);
      push(6'b000010, 0, 0, E_ID);
      push(6'b000010, 0, 0, c(3'b110, 5'b00000, 2'b00, 2'b00, 0, 0, 3'b000, 0, 1, 1));
      push(6'b000010, 0, 0, c(3'b111, 5'b10100, 2'b00, 2'b01, 0, 1, 3'b000, 0, 1, 1));
      push(6'b111000, 0, 0, E_IF);
      push(6'b111000, 0, 0, c(3'b001, 5'b10000, 2'b11, 2'b00, 0, 0, 3'b000, 0, 0, 0));
      push(6'b010000, 0, 0, E_IF);
      push(6'b010000, 0, 0, E_ID);
      push(6'b010000, 0, 0, c(3'b110, 5'b00000, 2'b00, 2'b00, 0, 0, 3'b100, 0, 0, 0));
      push(6'b010000, 0, 0, c(3'b111, 5'b10100, 2'b00, 2'b10, 0, 1, 3'b100, 0, 0, 0));
      push(6'b010001, 0, 0, E_IF);
      push(6'b010001, 0, 0, E_ID);
      push(6'b010001, 0, 0, c(3'b110, 5'b00000, 2'b00, 2'b00, 0, 0, 3'b100, 0, 1, 0));
      push(6'b010001, 0, 0, c(3'b111, 5'b10100, 2'b00, 2'b01, 0, 1, 3'b100, 0, 1, 0));
      while (sb_q.size() > 0) begin
         ent = sb_q.pop_front();
         @(negedge CLK);
         opcode = ent.op; zero = ent.z; sign = ent.s;
         #1;
         total++;
         if (w_act !== ent.e) begin
            bad++;
            $display("FAIL b2b op=%b got=%h want=%h", ent.op, w_act, ent.e);
         end
      end
   endtask

   task automatic test_halt;
      push(6'b111111, 0, 0, E_IF);
      for (int i = 0; i < 24; i++) push(6'b111111, i[0], i[1], E_ID);
      while (sb_q.size() > 0) begin
         ent = sb_q.pop_front();
         @(negedge CLK);
         opcode = ent.op; zero = ent.z; sign = ent.s;
         #1;
         total++;
         if (w_act !== ent.e) begin
            bad++;
            $display("FAIL halt got=%h want=%h", w_act, ent.e);
         end
      end
      Reset = 1'b1;
      #1;
      total++;
      if (w_act !== R0) begin
         bad++;
         $display("FAIL halt_reset got=%h want=%h", w_act, R0);
      end
      @(posedge CLK);
      #1 Reset = 1'b0;
   endtask

   task automatic test_reset_mid_sw;
      push(6'b110000, 0, 0, E_IF);
      push(6'b110000, 0, 0, E_ID);
      push(6'b110000, 0, 0, c(3'b010, 5'b00000, 2'b00, 2'b00, 0, 0, 3'b000, 0, 1, 1));
      push(6'b110000, 0, 0, c(3'b011, 5'b10001, 2'b00, 2'b00, 0, 0, 3'b000, 0, 1, 1));
      while (sb_q.size() > 0) begin
         ent = sb_q.pop_front();
         @(negedge CLK);
         opcode = ent.op; zero = ent.z; sign = ent.s;
         #1;
         total++;
         if (w_act !== ent.e) begin
            bad++;
            $display("FAIL sw_pre op=%b got=%h want=%h", ent.op, w_act, ent.e);
         end
      end
      #2 Reset = 1'b1;
      #1;
      total++;
      if (w_act !== R0) begin
         bad++;
         $display("FAIL sw_reset got=%h want=%h", w_act, R0);
      end
      @(posedge CLK);
      #1 Reset = 1'b0;
      push(6'b101010, 0, 0, E_IF);
      push(6'b101010, 0, 0, c(3'b001, 5'b10000, 2'b00, 2'b00, 0, 0, 3'b000, 0, 0, 0));
      while (sb_q.size() > 0) begin
         ent = sb_q.pop_front();
         @(negedge CLK);
         opcode = ent.op; zero = ent.z; sign = ent.s;
         #1;
         total++;
         if (w_act !== ent.e) begin
            bad++;
            $display("FAIL sw_after op=%b got=%h want=%h", ent.op, w_act, ent.e);
         end
      end
   endtask

   initial begin
      test_reset;
      test_alu;
      test_mem;
      test_branch;
      test_jump_nop;
      test_back_to_back;
      test_halt;
      test_reset_mid_sw;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
